// File: rtl/mux4_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 result mux.
// Optional per-ownership burst limit compiled in with MUX4_ARB_BURST_LIMIT_EN.
module mux4_arbiter #(
    parameter int MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o,
    output logic [1:0] sel_o,
    output logic       busy_o,
    output logic       handoff_o,
    output logic [7:0] burst_cnt_o
);

    // state   | meaning
    // S_IDLE  | no owner; sel holds the last owner
    // S_GRANT | one requester owns the mux (gnt one-hot)
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

`ifdef MUX4_ARB_BURST_LIMIT_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
    localparam logic [7:0] CNT_SAT   = 8'hFF;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic       handoff_q, handoff_d;
    logic [7:0] cnt_q, cnt_d;

    logic [3:0] own_onehot;
    logic [3:0] others;
    logic       own_req;
    logic       at_limit;
    logic [7:0] cnt_inc;
    logic [1:0] idle_pick;
    logic [1:0] xfer_pick;

    // First set bit scanning base+1 .. base+4 (mod 4); base itself is lowest priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        logic       found;
        rr_pick = base;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = base + i[1:0];
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        own_onehot = 4'b0001 << sel_q;
        others     = req_i & ~own_onehot;
        own_req    = req_i[sel_q];
        at_limit   = LIMIT_EN && (cnt_q == BURST_MAX);
        cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 8'd1;
        idle_pick  = rr_pick(req_i, last_q);
        xfer_pick  = rr_pick(others, last_q);
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        last_d    = last_q;
        handoff_d = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                gnt_d = 4'b0000;
                cnt_d = 8'd0;
                if (|req_i) begin
                    state_d = S_GRANT;
                    gnt_d   = 4'b0001 << idle_pick;
                    sel_d   = idle_pick;
                    last_d  = idle_pick;
                    cnt_d   = 8'd1;
                end
            end
            S_GRANT: begin
                if (own_req && !at_limit) begin
                    cnt_d = cnt_inc;
                end else if (|others) begin
                    gnt_d     = 4'b0001 << xfer_pick;
                    sel_d     = xfer_pick;
                    last_d    = xfer_pick;
                    handoff_d = 1'b1;
                    cnt_d     = 8'd1;
                end else if (own_req) begin
                    // limit expired with nobody waiting: keep the owner, restart the burst
                    cnt_d = 8'd1;
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = 4'b0000;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            last_q    <= 2'd3;
            handoff_q <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            handoff_q <= handoff_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign sel_o       = sel_q;
    assign busy_o      = (state_q == S_GRANT);
    assign handoff_o   = handoff_q;
    assign burst_cnt_o = cnt_q;

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed bench for mux4_arbiter; limit-specific scenarios follow MUX4_ARB_BURST_LIMIT_EN.
module tb_mux4_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       handoff;
    logic [7:0] burst_cnt;

    int tests;
    int fails;

    mux4_arbiter #(.MAX_BURST(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .gnt_o       (gnt),
        .sel_o       (sel),
        .busy_o      (busy),
        .handoff_o   (handoff),
        .burst_cnt_o (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req   = 4'b0000;
        #1 rst_n = 1'b0;
        #2;
        tests++;
        if ({gnt, sel, busy, handoff, burst_cnt} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_values: gnt=%b sel=%0d busy=%b handoff=%b cnt=%0d, expected all zero",
                     gnt, sel, busy, handoff, burst_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        #1;
        tests++;
        if (gnt !== 4'b0000) begin
            fails++;
            $display("FAIL single_no_comb_path: gnt=%b expected 0000", gnt);
        end
        step();
        tests++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || busy !== 1'b1 || burst_cnt !== 8'd1 || handoff !== 1'b0) begin
            fails++;
            $display("FAIL single_grant: gnt=%b sel=%0d busy=%b cnt=%0d handoff=%b, expected 0001 0 1 1 0",
                     gnt, sel, busy, burst_cnt, handoff);
        end
        req = 4'b0000;
        step();
        tests++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || burst_cnt !== 8'd0) begin
            fails++;
            $display("FAIL single_release: gnt=%b sel=%0d busy=%b cnt=%0d, expected 0000 0 0 0",
                     gnt, sel, busy, burst_cnt);
        end
        // last owner was 0, so from IDLE requester 1 outranks requester 0
        req = 4'b0011;
        step();
        tests++;
        if (gnt !== 4'b0010 || sel !== 2'd1 || handoff !== 1'b0) begin
            fails++;
            $display("FAIL idle_rr_priority: gnt=%b sel=%0d handoff=%b, expected 0010 1 0",
                     gnt, sel, handoff);
        end
    endtask

    task automatic test_round_robin();
        int cur;
        int nxt;
        do_reset();
        req = 4'b1111;
        step();
        tests++;
        if (gnt !== 4'b0001 || burst_cnt !== 8'd1 || handoff !== 1'b0) begin
            fails++;
            $display("FAIL rr_first: gnt=%b cnt=%0d handoff=%b, expected 0001 1 0", gnt, burst_cnt, handoff);
        end
        cur = 0;
        for (int n = 0; n < 4; n++) begin
            step();
            tests++;
            if (gnt !== (4'b0001 << cur) || burst_cnt !== 8'd2 || handoff !== 1'b0) begin
                fails++;
                $display("FAIL rr_hold[%0d]: gnt=%b cnt=%0d handoff=%b, expected %b 2 0",
                         n, gnt, burst_cnt, handoff, 4'b0001 << cur);
            end
            req[cur] = 1'b0;
            step();
            nxt = (cur + 1) % 4;
            tests++;
            if (gnt !== (4'b0001 << nxt) || sel !== nxt[1:0] || handoff !== 1'b1 ||
                burst_cnt !== 8'd1 || busy !== 1'b1) begin
                fails++;
                $display("FAIL rr_handoff[%0d]: gnt=%b sel=%0d handoff=%b cnt=%0d busy=%b, expected %b %0d 1 1 1",
                         n, gnt, sel, handoff, burst_cnt, busy, 4'b0001 << nxt, nxt);
            end
            req = 4'b1111;
            cur = nxt;
        end
    endtask

`ifdef MUX4_ARB_BURST_LIMIT_EN
    task automatic test_burst_alternate();
        int owner;
        int cnt;
        int hand;
        do_reset();
        req = 4'b0011;
        for (int i = 1; i <= 12; i++) begin
            step();
            owner = ((i - 1) / 4) % 2;
            cnt   = ((i - 1) % 4) + 1;
            hand  = (i > 1 && cnt == 1) ? 1 : 0;
            tests++;
            if (gnt !== (4'b0001 << owner) || burst_cnt !== cnt[7:0] || handoff !== hand[0]) begin
                fails++;
                $display("FAIL burst_alt[%0d]: gnt=%b cnt=%0d handoff=%b, expected %b %0d %0d",
                         i, gnt, burst_cnt, handoff, 4'b0001 << owner, cnt, hand);
            end
        end
    endtask

    task automatic test_burst_single();
        int cnt;
        do_reset();
        req = 4'b0100;
        for (int i = 1; i <= 10; i++) begin
            step();
            cnt = ((i - 1) % 4) + 1;
            tests++;
            if (gnt !== 4'b0100 || burst_cnt !== cnt[7:0] || handoff !== 1'b0) begin
                fails++;
                $display("FAIL burst_single[%0d]: gnt=%b cnt=%0d handoff=%b, expected 0100 %0d 0",
                         i, gnt, burst_cnt, handoff, cnt);
            end
        end
    endtask
`else
    task automatic test_hold_no_limit();
        do_reset();
        req = 4'b0011;
        for (int i = 1; i <= 20; i++) begin
            step();
            tests++;
            if (gnt !== 4'b0001 || burst_cnt !== i[7:0] || handoff !== 1'b0) begin
                fails++;
                $display("FAIL hold[%0d]: gnt=%b cnt=%0d handoff=%b, expected 0001 %0d 0",
                         i, gnt, burst_cnt, handoff, i);
            end
        end
        repeat (240) step();
        tests++;
        if (gnt !== 4'b0001 || burst_cnt !== 8'd255) begin
            fails++;
            $display("FAIL cnt_saturate: gnt=%b cnt=%0d, expected 0001 255", gnt, burst_cnt);
        end
    endtask
`endif

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0100;
        step();
        tests++;
        if (gnt !== 4'b0100 || sel !== 2'd2) begin
            fails++;
            $display("FAIL midrst_pre: gnt=%b sel=%0d, expected 0100 2", gnt, sel);
        end
        step();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || burst_cnt !== 8'd0 || sel !== 2'd0) begin
            fails++;
            $display("FAIL midrst_async: gnt=%b busy=%b cnt=%0d sel=%0d, expected 0000 0 0 0",
                     gnt, busy, burst_cnt, sel);
        end
        req = 4'b1100;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        tests++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || burst_cnt !== 8'd1) begin
            fails++;
            $display("FAIL midrst_first_grant: gnt=%b sel=%0d cnt=%0d, expected 0100 2 1",
                     gnt, sel, burst_cnt);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_round_robin();
`ifdef MUX4_ARB_BURST_LIMIT_EN
        test_burst_alternate();
        test_burst_single();
`else
        test_hold_no_limit();
`endif
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux4_arbiter.md
# mux4_arbiter

Round-robin arbiter that shares one 4-input 32-bit selection datapath (the 4:1 result mux in the CPU datapath) between four requesters. It grants one requester at a time and drives the mux's 2-bit select so that the owner's operand reaches the shared `Result` bus. An optional burst limit forces hand-off after a fixed number of cycles. The block sits beside the mux: its `sel` output feeds the mux `oper` input, and its `gnt` outputs go back to the requesters.

## Interface
- `MAX_BURST`, default 8: maximum consecutive grant cycles per ownership when the burst limit is compiled in. Legal range 1..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request per requester; bit N is requester N (drives mux input xN).
- `gnt`  out  4  one-hot or zero grant, registered.
- `sel`  out  2  mux select; equals the index of the set `gnt` bit while granted, and holds the last owner while idle.
- `busy`  out  1  high while in GRANT (equals `|gnt`).
- `handoff`  out  1  one-cycle pulse in the first cycle of a grant that transferred directly from another owner (no idle cycle).
- `burst_cnt`  out  8  cycles in the current ownership, counting from 1; 0 when idle.

## Operation
- State: `IDLE`, `GRANT`. Internal round-robin pointer `last[1:0]`, which holds the most recent owner.
- Winner function: scan indices `last+1`, `last+2`, `last+3`, `last+4` (mod 4) and take the first with `req` set. `last` itself is lowest priority.
- **IDLE**:
  - `gnt` = 0, `busy` = 0, `burst_cnt` = 0.
  - If `|req`: go to GRANT next edge with `gnt[w]` = 1, `sel` = w, `burst_cnt` = 1, `last` = w.
- **GRANT**, owner `o`, with release condition `rel = !req[o]`, or `rel = !req[o] | (burst_cnt == MAX_BURST)` when the limit is enabled:
  - `!rel`: hold the grant, `burst_cnt` += 1.
  - `rel`, and another requester is pending (any `req[k]`, k≠o): next edge grants the winner among k≠o. `handoff` = 1, `burst_cnt` = 1, `last` = new owner.
  - `rel` from limit expiry, `req[o]` still high, and no other request: keep `o`. `burst_cnt` restarts at 1, `handoff` = 0, no bubble.
  - `rel` from `!req[o]`, and no other request: go to IDLE next edge. `sel` holds `o`.
- Requests from non-owners never disturb the current grant.
- Deasserting `req[o]` ends the grant one edge later. The owner must not drive meaningful data in the cycle after it drops `req`.
- `burst_cnt` saturates at 255 when the limit is disabled.
- Reset values: state IDLE, `gnt` = 0, `sel` = 0, `busy` = 0, `handoff` = 0, `burst_cnt` = 0, `last` = 3 (requester 0 has first priority).

## Timing
- All outputs are registered. There are no combinational paths from `req` to any output.
- Request-to-grant latency is 1 cycle from IDLE: `req` is sampled high at edge k, and `gnt` is high after edge k.
- Direct hand-off has zero idle cycles: the old grant falls and the new grant rises on the same edge.
- Mux `Result` is valid for the owner in every cycle that its `gnt` bit is high. `sel` changes only on edges where `gnt` changes.
- Asserting `rst_n` low mid-grant clears `gnt` and `busy` immediately (asynchronously). After release, the first grant follows the reset priority.

## Configuration
- `MUX4_ARB_BURST_LIMIT_EN`:
  - Defined: ownership is forcibly released after `MAX_BURST` cycles whenever another request is pending. This guarantees each requester a grant within 3×`MAX_BURST`+1 cycles.
  - Undefined: the owner keeps the grant until it drops `req`. `MAX_BURST` is ignored.

## Test plan
- Reset release, then `req`=0001 -> after 1 edge `gnt`=0001, `sel`=0, `busy`=1, `burst_cnt`=1. Drop `req` -> next edge `gnt`=0, `sel` stays 0.
- After reset, `req`=1111 held; each owner drops its `req` after 2 cycles then reasserts -> grant order 0,1,2,3,0. `handoff`=1 on every transfer, with no idle cycle.
- Macro defined, `MAX_BURST`=4, `req`=0011 held -> owner 0 for 4 cycles, then owner 1 for 4 cycles, alternating. `burst_cnt` sequence is 1,2,3,4,1.
- Macro defined, `MAX_BURST`=4, only `req`=0100 held for 10 cycles -> `gnt`=0100 continuously, `burst_cnt` 1,2,3,4,1,2,3,4,1,2, `handoff` never set.
- Macro undefined, `req`=0011 held for 20 cycles -> `gnt`=0001 for all 20 cycles. `burst_cnt` reaches 20.
- Owner 2 granted, `rst_n` pulsed low mid-cycle -> `gnt`=0 and `busy`=0 immediately. After release with `req`=1100 -> first grant goes to requester 2 (scan from index 0 finds 2 before 3).
